// File: rtl/fft_iter_core.sv
// Iterative in-place radix-2 DIT FFT core with an external twiddle ROM.
// Latency: N load beats, 2*N*N_LOG2 compute cycles, N unload beats.
// Backpressure: in_valid_i gaps stall LOAD; out_ready_i low holds UNLOAD data stable.
//
// Ports:
//   clk, rst (sync, active-low)  - clock and reset
//   start_i, inverse_i, scale_i  - start a transform; mode bits latched on accepted start
//   in_valid_i/in_ready_o/in_R_i/in_I_i        - natural-order input samples
//   out_valid_o/out_ready_i/out_R_o/out_I_o/out_last_o - natural-order results
//   tw_addr_o/tw_R_i/tw_I_i      - twiddle ROM exp(-j2*pi*k/N), 1-cycle read latency
//   busy_o, done_o, ovf_o        - not idle, completion pulse, sticky saturation flag
module fft_iter_core #(
  parameter int N_LOG2 = 3,
  parameter int DW     = 16,
  parameter int FRAC   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              inverse_i,
  input  logic              scale_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DW-1:0]     in_R_i,
  input  logic [DW-1:0]     in_I_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DW-1:0]     out_R_o,
  output logic [DW-1:0]     out_I_o,
  output logic              out_last_o,
  output logic [N_LOG2-2:0] tw_addr_o,
  input  logic [DW-1:0]     tw_R_i,
  input  logic [DW-1:0]     tw_I_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              ovf_o
);

  localparam int N  = 1 << N_LOG2;
  localparam int SW = $clog2(N_LOG2);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_COMPUTE, S_UNLOAD} state_t;

  state_t state, state_nxt;

  logic [N_LOG2-1:0] cnt;
  logic [1:0]        phase;
  logic [N_LOG2-2:0] bfly;
  logic [SW-1:0]     stage;
  logic              inv_q, scl_q;

  logic [DW-1:0] mem_r [N];
  logic [DW-1:0] mem_i [N];

  logic signed [DW-1:0] a_r, a_i, b_r, b_i;
  logic signed [DW:0]   bw_r, bw_i;

  function automatic logic [N_LOG2-1:0] bitrev(input logic [N_LOG2-1:0] v);
    logic [N_LOG2-1:0] r;
    for (int i = 0; i < N_LOG2; i++) r[i] = v[N_LOG2-1-i];
    return r;
  endfunction

  // Scale halves the DW+1 sum; otherwise clamp to the DW-bit range.
  function automatic logic [DW-1:0] fit(input logic [DW:0] v, input logic scl);
    logic [DW-1:0] r;
    if (scl)                    r = v[DW:1];
    else if (v[DW] != v[DW-1])  r = v[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    else                        r = v[DW-1:0];
    return r;
  endfunction

  // ---------------------------------------------------------------- control
  logic cnt_last, bfly_last, stage_last, compute_end, ld_fire, ul_fire;

  assign cnt_last    = (cnt == N_LOG2'(N - 1));
  assign bfly_last   = (bfly == '1);
  assign stage_last  = (stage == SW'(N_LOG2 - 1));
  assign compute_end = (phase == 2'd3) && bfly_last && stage_last;
  assign ld_fire     = (state == S_LOAD) && in_valid_i;
  assign ul_fire     = (state == S_UNLOAD) && out_ready_i;

  always_ff @(posedge clk) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    busy_o      = 1'b1;
    unique case (state)
      S_IDLE: begin
        busy_o = 1'b0;
        if (start_i) state_nxt = S_LOAD;
      end
      S_LOAD: begin
        in_ready_o = 1'b1;
        if (in_valid_i && cnt_last) state_nxt = S_COMPUTE;
      end
      S_COMPUTE: begin
        if (compute_end) state_nxt = S_UNLOAD;
      end
      S_UNLOAD: begin
        out_valid_o = 1'b1;
        if (out_ready_i && cnt_last) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // ------------------------------------------------------- butterfly address
  // Butterfly b of stage s: insert a 0 at bit s of b to get the top leg, the
  // bottom leg sets that bit. Position within the group is b's low s bits.
  logic [N_LOG2-1:0] one_hot, low_mask, bf_ext, a_addr, b_addr;
  logic [N_LOG2-2:0] k_idx, tw_idx;
  logic [SW-1:0]     tw_sh;

  assign one_hot  = N_LOG2'(1) << stage;
  assign low_mask = one_hot - N_LOG2'(1);
  assign bf_ext   = {1'b0, bfly};
  assign a_addr   = (bf_ext & low_mask) | ((bf_ext & ~low_mask) << 1);
  assign b_addr   = a_addr | one_hot;
  assign k_idx    = bfly & low_mask[N_LOG2-2:0];
  assign tw_sh    = SW'(N_LOG2 - 1) - stage;
  assign tw_idx   = k_idx << tw_sh;

  // ---------------------------------------------------------------- datapath
  logic signed [DW-1:0]   w_r, w_i;
  logic signed [2*DW-1:0] br_x, bi_x, wr_x, wi_x;
  logic signed [2*DW-1:0] pr_full, pi_full;
  logic signed [DW:0]     ax_r, ax_i, sp_r, sp_i, sm_r, sm_i;
  logic                   clip_any;
  logic                   unused_hi;

  assign w_r  = $signed(tw_R_i);
  assign w_i  = inv_q ? -$signed(tw_I_i) : $signed(tw_I_i);
  assign br_x = (2*DW)'(b_r);
  assign bi_x = (2*DW)'(b_i);
  assign wr_x = (2*DW)'(w_r);
  assign wi_x = (2*DW)'(w_i);

  // Full-width complex product, truncated back to the sample's Q format.
  assign pr_full = (br_x * wr_x - bi_x * wi_x) >>> FRAC;
  assign pi_full = (br_x * wi_x + bi_x * wr_x) >>> FRAC;
  // With |W| <= 1 the product of a DW-bit sample fits in DW+1 bits.
  assign unused_hi = ^{pr_full[2*DW-1:DW+1], pi_full[2*DW-1:DW+1]};

  assign ax_r = (DW+1)'(a_r);
  assign ax_i = (DW+1)'(a_i);
  assign sp_r = ax_r + bw_r;
  assign sp_i = ax_i + bw_i;
  assign sm_r = ax_r - bw_r;
  assign sm_i = ax_i - bw_i;

  assign clip_any = ~scl_q & ((sp_r[DW] ^ sp_r[DW-1]) | (sp_i[DW] ^ sp_i[DW-1]) |
                              (sm_r[DW] ^ sm_r[DW-1]) | (sm_i[DW] ^ sm_i[DW-1]));

  // Phase 0 reads both legs and issues the twiddle address, phase 1 waits on
  // the ROM, phase 2 registers the product, phase 3 writes back in place.
  always_ff @(posedge clk) begin
    if (state == S_COMPUTE) begin
      if (phase == 2'd0) begin
        a_r <= mem_r[a_addr];
        a_i <= mem_i[a_addr];
        b_r <= mem_r[b_addr];
        b_i <= mem_i[b_addr];
      end
      if (phase == 2'd2) begin
        bw_r <= pr_full[DW:0];
        bw_i <= pi_full[DW:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (ld_fire) begin
      mem_r[bitrev(cnt)] <= in_R_i;
      mem_i[bitrev(cnt)] <= in_I_i;
    end else if (state == S_COMPUTE && phase == 2'd3) begin
      mem_r[a_addr] <= fit(sp_r, scl_q);
      mem_i[a_addr] <= fit(sp_i, scl_q);
      mem_r[b_addr] <= fit(sm_r, scl_q);
      mem_i[b_addr] <= fit(sm_i, scl_q);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt       <= '0;
      phase     <= '0;
      bfly      <= '0;
      stage     <= '0;
      inv_q     <= 1'b0;
      scl_q     <= 1'b0;
      ovf_o     <= 1'b0;
      done_o    <= 1'b0;
      tw_addr_o <= '0;
    end else begin
      done_o <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start_i) begin
            inv_q <= inverse_i;
            scl_q <= scale_i;
            ovf_o <= 1'b0;
            cnt   <= '0;
            phase <= '0;
            bfly  <= '0;
            stage <= '0;
          end
        end
        S_LOAD: begin
          // Wraps back to 0 after the last sample, ready for UNLOAD.
          if (ld_fire) cnt <= cnt + N_LOG2'(1);
        end
        S_COMPUTE: begin
          phase <= phase + 2'd1;
          if (phase == 2'd0) tw_addr_o <= tw_idx;
          if (phase == 2'd3) begin
            if (clip_any) ovf_o <= 1'b1;
            if (bfly_last) begin
              bfly  <= '0;
              stage <= stage_last ? '0 : stage + SW'(1);
            end else begin
              bfly <= bfly + (N_LOG2-1)'(1);
            end
          end
        end
        S_UNLOAD: begin
          if (ul_fire) begin
            cnt <= cnt + N_LOG2'(1);
            if (cnt_last) done_o <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // ------------------------------------------------------------------ output
  assign out_last_o = (state == S_UNLOAD) && cnt_last;
  assign out_R_o    = (state == S_UNLOAD) ? mem_r[cnt] : '0;
  assign out_I_o    = (state == S_UNLOAD) ? mem_i[cnt] : '0;

endmodule
